// File: rtl/bcd_autoscale_pkg.sv
// Shared constants for the BCD auto-scaling display formatter.
package bcd_autoscale_pkg;

  // Working digit layout: {dp, bcd[3:0]}
  localparam int unsigned DIG_W        = 5;
  localparam int unsigned BCD_W        = 4;
  localparam int unsigned DP_BIT       = 4;

  // Guard-digit value at or above which the display rounds up
  localparam int unsigned GUARD_THRESH = 5;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/bcd_round_inc.sv
// N_DIG-digit BCD incrementer (+1) with decimal carry-out.
module bcd_round_inc #(
  parameter int unsigned N_DIG = 4
) (
  input  logic [4*N_DIG-1:0] bcd,
  output logic [4*N_DIG-1:0] sum,
  output logic               carry
);

  logic c;

  // Ripple +1 from the least significant digit, wrapping 9 -> 0
  always_comb begin
    c     = 1'b1;
    sum   = '0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (c) begin
        if (bcd[4*i +: 4] >= 4'd9) begin
          sum[4*i +: 4] = 4'd0;
        end else begin
          sum[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          c             = 1'b0;
        end
      end else begin
        sum[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    carry = c;
  end

endmodule

// File: rtl/bcd_autoscale.sv
// BCD auto-scaler: strips leading zero digits and presents the top N_OUT
// digits with a decimal-point marker on the original least significant digit.
// Optional rounding on the first hidden digit: define BCD_AUTOSCALE_ROUND_EN.
module bcd_autoscale
  import bcd_autoscale_pkg::*;
#(
  parameter int unsigned N_IN  = 11,
  parameter int unsigned N_OUT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [4*N_IN-1:0]        bcd_in,
  output logic [5*N_OUT-1:0]       dig_out,
  output logic [$clog2(N_IN)-1:0]  shift_cnt,
  output logic                     zero,
  output logic                     sat,
  output logic                     ready,
  output logic                     done_tick
);

  localparam int unsigned CNT_W  = $clog2(N_IN);
  localparam int unsigned WORK_W = DIG_W * N_IN;
  localparam int unsigned OUT_W  = DIG_W * N_OUT;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] load_val;
  logic [CNT_W-1:0]  cnt;
  logic [OUT_W-1:0]  top_dig;
  logic              top_zero;
  logic              all_zero;

  assign top_dig   = work[WORK_W-1 -: OUT_W];
  assign top_zero  = (work[WORK_W-1 -: DIG_W] == '0);
  assign ready     = (state == ST_IDLE);
  assign done_tick = (state == ST_DONE);

  // Widen input digits to 5 bits, marking digit 0 as the decimal point
  always_comb begin
    load_val = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      load_val[DIG_W*i +: DIG_W] = {(i == 0), bcd_in[BCD_W*i +: BCD_W]};
    end
  end

  // Input was zero iff no nonzero BCD field survives in the working register
  always_comb begin
    all_zero = 1'b1;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (work[DIG_W*i +: BCD_W] != '0) all_zero = 1'b0;
    end
  end

`ifdef BCD_AUTOSCALE_ROUND_EN
  localparam int unsigned GUARD_IDX = N_IN - 1 - N_OUT;

  logic [BCD_W*N_OUT-1:0] top_bcd;
  logic [BCD_W*N_OUT-1:0] inc_sum;
  logic                   inc_carry;
  logic                   round_up;
  logic                   sat_next;
  logic                   sat_r;
  logic [OUT_W-1:0]       rnd_dig;

  // Strip dp bits for the incrementer
  always_comb begin
    top_bcd = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      top_bcd[BCD_W*j +: BCD_W] = top_dig[DIG_W*j +: BCD_W];
    end
  end

  bcd_round_inc #(.N_DIG(N_OUT)) u_round_inc (
    .bcd   (top_bcd),
    .sum   (inc_sum),
    .carry (inc_carry)
  );

  // Select truncated, rounded or saturated digits; dp bits pass through
  always_comb begin
    rnd_dig  = '0;
    round_up = (work[DIG_W*GUARD_IDX +: BCD_W] >= BCD_W'(GUARD_THRESH));
    sat_next = round_up & inc_carry;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      rnd_dig[DIG_W*j + DP_BIT] = top_dig[DIG_W*j + DP_BIT];
      if (!round_up)
        rnd_dig[DIG_W*j +: BCD_W] = top_dig[DIG_W*j +: BCD_W];
      else if (inc_carry)
        rnd_dig[DIG_W*j +: BCD_W] = 4'd9;
      else
        rnd_dig[DIG_W*j +: BCD_W] = inc_sum[BCD_W*j +: BCD_W];
    end
  end

  assign sat = sat_r;
`else
  assign sat = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (!top_zero) begin
`ifdef BCD_AUTOSCALE_ROUND_EN
          state_next = ST_ROUND;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef BCD_AUTOSCALE_ROUND_EN
      ST_ROUND: state_next = ST_DONE;
`endif
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Working register, shift counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      work      <= '0;
      cnt       <= '0;
      dig_out   <= '0;
      shift_cnt <= '0;
      zero      <= 1'b0;
`ifdef BCD_AUTOSCALE_ROUND_EN
      sat_r     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            work <= load_val;
            cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          if (top_zero) begin
            work <= {work[WORK_W-DIG_W-1:0], DIG_W'(0)};
            cnt  <= cnt + CNT_W'(1);
          end
`ifndef BCD_AUTOSCALE_ROUND_EN
          else begin
            dig_out   <= top_dig;
            shift_cnt <= cnt;
            zero      <= all_zero;
          end
`endif
        end
`ifdef BCD_AUTOSCALE_ROUND_EN
        ST_ROUND: begin
          dig_out   <= rnd_dig;
          shift_cnt <= cnt;
          zero      <= all_zero;
          sat_r     <= sat_next;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_autoscale.sv
// Scoreboard bench for bcd_autoscale (N_IN=11, N_OUT=4), either build option.
module tb_bcd_autoscale;

  localparam int unsigned N_IN  = 11;
  localparam int unsigned N_OUT = 4;

`ifdef BCD_AUTOSCALE_ROUND_EN
  localparam int EXTRA = 1;
  localparam bit RND   = 1'b1;
`else
  localparam int EXTRA = 0;
  localparam bit RND   = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [4*N_IN-1:0]    bcd_in;
  logic [5*N_OUT-1:0]   dig_out;
  logic [3:0]           shift_cnt;
  logic                 zero;
  logic                 sat;
  logic                 ready;
  logic                 done_tick;

  bcd_autoscale #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bcd_in    (bcd_in),
    .dig_out   (dig_out),
    .shift_cnt (shift_cnt),
    .zero      (zero),
    .sat       (sat),
    .ready     (ready),
    .done_tick (done_tick)
  );

  typedef struct {
    logic [19:0] dig;
    logic [3:0]  sc;
    logic        z;
    logic        s;
    int          lat;
    int          c0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] d4(input logic [4:0] a, input logic [4:0] b,
                                     input logic [4:0] c, input logic [4:0] d);
    return {a, b, c, d};
  endfunction

  // Monitor: pop and compare whenever a result is strobed
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done_tick) begin
      chk("ready_low_on_done", 32'(ready), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done_tick with empty scoreboard (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("dig_out",   32'(dig_out),   32'(e.dig));
        chk("shift_cnt", 32'(shift_cnt), 32'(e.sc));
        chk("zero",      32'(zero),      32'(e.z));
        chk("sat",       32'(sat),       32'(e.s));
        chk("latency",   32'(cyc - e.c0), 32'(e.lat));
      end
    end
  end

  // Issue one conversion and push its expected result
  task automatic issue(input logic [43:0] bcd, input logic [3:0] sc, input logic z,
                       input logic [19:0] dig_t, input logic [19:0] dig_r,
                       input logic sat_r, input int lat);
    exp_t e;
    @(posedge clk); #1;
    bcd_in = bcd;
    start  = 1'b1;
    e.dig  = RND ? dig_r : dig_t;
    e.sc   = sc;
    e.z    = z;
    e.s    = RND ? sat_r : 1'b0;
    e.lat  = lat + EXTRA;
    e.c0   = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run(input logic [43:0] bcd, input logic [3:0] sc, input logic z,
                     input logic [19:0] dig_t, input logic [19:0] dig_r,
                     input logic sat_r, input int lat);
    issue(bcd, sc, z, dig_t, dig_r, sat_r, lat);
    wait_empty();
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready",     32'(ready),     32'd1);
    chk("reset_done",      32'(done_tick), 32'd0);
    chk("reset_dig_out",   32'(dig_out),   32'd0);
    chk("reset_shift_cnt", 32'(shift_cnt), 32'd0);
    chk("reset_zero",      32'(zero),      32'd0);
    chk("reset_sat",       32'(sat),       32'd0);
    reset = 1'b0;

    //   bcd_in            k      zero  truncated             rounded               sat lat
    run(44'h00000012345, 4'd6,  1'b0, d4(5'h01,5'h02,5'h03,5'h04), d4(5'h01,5'h02,5'h03,5'h05), 1'b0, 8);
    run(44'h00000000000, 4'd10, 1'b1, d4(5'h10,5'h00,5'h00,5'h00), d4(5'h10,5'h00,5'h00,5'h00), 1'b0, 12);
    run(44'h12345678901, 4'd0,  1'b0, d4(5'h01,5'h02,5'h03,5'h04), d4(5'h01,5'h02,5'h03,5'h05), 1'b0, 2);
    run(44'h00000099996, 4'd6,  1'b0, d4(5'h09,5'h09,5'h09,5'h09), d4(5'h09,5'h09,5'h09,5'h09), 1'b1, 8);
    run(44'h00000000012, 4'd9,  1'b0, d4(5'h01,5'h12,5'h00,5'h00), d4(5'h01,5'h12,5'h00,5'h00), 1'b0, 11);
    run(44'h00000000005, 4'd10, 1'b0, d4(5'h15,5'h00,5'h00,5'h00), d4(5'h15,5'h00,5'h00,5'h00), 1'b0, 12);
    run(44'h00019995000, 4'd3,  1'b0, d4(5'h01,5'h09,5'h09,5'h09), d4(5'h02,5'h00,5'h00,5'h00), 1'b0, 5);
    run(44'h00019994999, 4'd3,  1'b0, d4(5'h01,5'h09,5'h09,5'h09), d4(5'h01,5'h09,5'h09,5'h09), 1'b0, 5);

    // Second start during SHIFT is ignored; previous result stays put meanwhile
    issue(44'h00000012345, 4'd6, 1'b0, d4(5'h01,5'h02,5'h03,5'h04), d4(5'h01,5'h02,5'h03,5'h05), 1'b0, 8);
    @(posedge clk); #1;
    bcd_in = 44'h12345678901;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    @(negedge clk);
    chk("hold_dig_out",   32'(dig_out),   32'(d4(5'h01,5'h09,5'h09,5'h09)));
    chk("hold_shift_cnt", 32'(shift_cnt), 32'd3);
    chk("busy_not_ready", 32'(ready),     32'd0);
    wait_empty();
    repeat (20) @(posedge clk);

    // Reset in the middle of SHIFT: back to idle, outputs cleared, no strobe
    @(posedge clk); #1;
    bcd_in = 44'h00000012345;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready",     32'(ready),     32'd1);
    chk("midrst_done",      32'(done_tick), 32'd0);
    chk("midrst_dig_out",   32'(dig_out),   32'd0);
    chk("midrst_shift_cnt", 32'(shift_cnt), 32'd0);
    chk("midrst_zero",      32'(zero),      32'd0);
    reset = 1'b0;
    repeat (20) @(posedge clk);

    // Normal operation after the aborted conversion
    run(44'h00123456789, 4'd2, 1'b0, d4(5'h01,5'h02,5'h03,5'h04), d4(5'h01,5'h02,5'h03,5'h05), 1'b0, 4);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
